// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA command-generation stage.
package dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE
  } state_e;

  function automatic int unsigned max_size(
    input int unsigned strb_wd
  );
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) <= strb_wd) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Beats for the next burst: min of remaining, room to the
// next 4 KB boundary, and the per-burst beat limit.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WD = 32,
  parameter int MAX_BEATS   = 256
) (
  input  logic [AXI_ADDR_WD-1:0] addr_i,
  input  logic [2:0]             size_i,
  input  logic [AXI_ADDR_WD-1:0] rem_i,
  output logic [AXI_ADDR_WD-1:0] beats_o
);

  logic [AXI_ADDR_WD-1:0] span;
  logic [AXI_ADDR_WD-1:0] b4k;
  logic [AXI_ADDR_WD-1:0] lim;

  assign span = AXI_ADDR_WD'(BOUNDARY_4K)
              - {{(AXI_ADDR_WD-12){1'b0}}, addr_i[11:0]};
  assign b4k  = span >> size_i;
  assign lim  = AXI_ADDR_WD'(MAX_BEATS);

  always_comb begin
    beats_o = rem_i;
    if (b4k < beats_o) beats_o = b4k;
    if (lim < beats_o) beats_o = lim;
  end

endmodule

// File: rtl/dma_burst_splitter.sv
// Splits one transfer descriptor into AXI INCR burst commands
// that respect the beat limit and never cross 4 KB.
module dma_burst_splitter
  import dma_pkg::*;
#(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_ADDR_WD = 32,
  parameter int AXI_STRB_WD = 4,
  parameter int MAX_BEATS   = 256
) (
  input  logic                   AXI_ACLK,
  input  logic                   AXI_ARESET,
  input  logic                   desc_valid,
  input  logic [AXI_ADDR_WD-1:0] desc_addr,
  input  logic [AXI_ID_WD-1:0]   desc_id,
  input  logic [2:0]             desc_size,
  input  logic [AXI_ADDR_WD-1:0] desc_bytes,
  output logic                   desc_ready,
  output logic                   desc_done,
  output logic                   desc_err,
  output logic                   cmd_valid,
  output logic [AXI_ADDR_WD-1:0] cmd_addr,
  output logic [AXI_ID_WD-1:0]   cmd_id,
  output logic [1:0]             cmd_burst,
  output logic [2:0]             cmd_size,
  output logic [AXI_ADDR_WD-1:0] cmd_len,
  input  logic                   cmd_ready,
  input  logic                   cmd_abort
);

  localparam int AW = AXI_ADDR_WD;
  localparam logic [2:0] MAX_SZ =
    3'(max_size(AXI_STRB_WD));

  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] beats_q, beats_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [AW-1:0] clen_q, clen_d;
  logic [AXI_ID_WD-1:0] id_q, id_d;
  logic [2:0] size_q, size_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [AW-1:0] calc_beats;
  logic [AW-1:0] mask;
  logic bad;
  logic last_hs;

  dma_burst_calc #(
    .AXI_ADDR_WD(AXI_ADDR_WD),
    .MAX_BEATS  (MAX_BEATS)
  ) u_calc (
    .addr_i (addr_q),
    .size_i (size_q),
    .rem_i  (rem_q),
    .beats_o(calc_beats)
  );

  assign mask = (AW'(1) << desc_size) - AW'(1);
  assign bad  = (desc_size > MAX_SZ)
              | (|(desc_addr & mask))
              | (|(desc_bytes & mask));

  // Final handshake completes the descriptor in the same cycle.
  assign last_hs = (state_q == ISSUE) & cmd_ready
                 & ~cmd_abort & (rem_q == beats_q);

  assign desc_ready = (state_q == IDLE);
  assign cmd_valid  = (state_q == ISSUE);
  assign desc_done  = done_q | last_hs;
  assign desc_err   = err_q;
  assign cmd_addr   = caddr_q;
  assign cmd_len    = clen_q;
  assign cmd_id     = id_q;
  assign cmd_size   = size_q;
  assign cmd_burst  = BURST_INCR;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    caddr_d = caddr_q;
    clen_d  = clen_q;
    id_d    = id_q;
    size_d  = size_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (desc_valid) begin
          addr_d = desc_addr;
          id_d   = desc_id;
          size_d = desc_size;
          rem_d  = desc_bytes >> desc_size;
          if (bad) begin
            err_d = 1'b1;
          end else if (desc_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cmd_abort) begin
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          beats_d = calc_beats;
          clen_d  = calc_beats - AW'(1);
          caddr_d = addr_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_abort) begin
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = IDLE;
        end else if (cmd_ready) begin
          addr_d  = addr_q + (beats_q << size_q);
          rem_d   = rem_q - beats_q;
          state_d = (rem_q == beats_q) ? IDLE : CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      caddr_q <= '0;
      clen_q  <= '0;
      id_q    <= '0;
      size_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      caddr_q <= caddr_d;
      clen_q  <= clen_d;
      id_q    <= id_d;
      size_q  <= size_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Directed vector bench for dma_burst_splitter with
// hand-written abort, reset and backpressure sequences.
module tb_dma_burst_splitter;

  localparam int AW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid;
  logic [AW-1:0] desc_addr;
  logic [IW-1:0] desc_id;
  logic [2:0]    desc_size;
  logic [AW-1:0] desc_bytes;
  logic          desc_ready;
  logic          desc_done;
  logic          desc_err;
  logic          cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic [IW-1:0] cmd_id;
  logic [1:0]    cmd_burst;
  logic [2:0]    cmd_size;
  logic [AW-1:0] cmd_len;
  logic          cmd_ready;
  logic          cmd_abort;

  always #5 clk = ~clk;

  dma_burst_splitter #(
    .AXI_ID_WD  (IW),
    .AXI_ADDR_WD(AW),
    .AXI_STRB_WD(4),
    .MAX_BEATS  (256)
  ) dut (
    .AXI_ACLK  (clk),
    .AXI_ARESET(rst),
    .desc_valid(desc_valid),
    .desc_addr (desc_addr),
    .desc_id   (desc_id),
    .desc_size (desc_size),
    .desc_bytes(desc_bytes),
    .desc_ready(desc_ready),
    .desc_done (desc_done),
    .desc_err  (desc_err),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_id    (cmd_id),
    .cmd_burst (cmd_burst),
    .cmd_size  (cmd_size),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .cmd_abort (cmd_abort)
  );

  typedef struct {
    logic [AW-1:0]      addr;
    logic [2:0]         size;
    logic [AW-1:0]      bytes;
    logic [IW-1:0]      id;
    int                 ncmd;
    int                 done;
    int                 err;
    logic [3:0][AW-1:0] ea;
    logic [3:0][AW-1:0] el;
  } vec_t;

  vec_t vecs[12];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic addv(input logic [AW-1:0] a,
                      input logic [2:0] s,
                      input logic [AW-1:0] b,
                      input logic [IW-1:0] id,
                      input int n, input int d,
                      input int e);
    vecs[nv].addr  = a;
    vecs[nv].size  = s;
    vecs[nv].bytes = b;
    vecs[nv].id    = id;
    vecs[nv].ncmd  = n;
    vecs[nv].done  = d;
    vecs[nv].err   = e;
    vecs[nv].ea    = '0;
    vecs[nv].el    = '0;
    nv++;
  endtask

  task automatic addc(input int j,
                      input logic [AW-1:0] a,
                      input logic [AW-1:0] l);
    vecs[nv-1].ea[j] = a;
    vecs[nv-1].el[j] = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a,
                      input logic [2:0] s,
                      input logic [AW-1:0] b,
                      input logic [IW-1:0] id);
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_size  = s;
    desc_bytes = b;
    desc_id    = id;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int i;
    for (i = 0; i < 10; i++) begin
      if (cmd_valid) break;
      tick();
    end
    chk({nm, " wait cmd_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int n, nd, ne, first, lcyc, dcyc;
    string p;
    v = vecs[k];
    p = $sformatf("v%0d", k);
    cmd_ready = 1'b1;
    send(v.addr, v.size, v.bytes, v.id);
    n = 0; nd = 0; ne = 0;
    first = -1; lcyc = -1; dcyc = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (cmd_valid) begin
        if (n < 4) begin
          chk($sformatf("%s addr%0d", p, n),
              cmd_addr, v.ea[n]);
          chk($sformatf("%s len%0d", p, n),
              cmd_len, v.el[n]);
        end
        chk($sformatf("%s id/burst/size%0d", p, n),
            {25'd0, cmd_id, cmd_burst, cmd_size},
            {25'd0, v.id, 2'b01, v.size});
        if (first < 0) first = c;
        lcyc = c;
        n++;
      end
      if (desc_done) begin
        nd++;
        dcyc = c;
      end
      if (desc_err) ne++;
      if (desc_done && desc_err)
        chk({p, " done&err"}, 32'd1, 32'd0);
      tick();
    end
    chk({p, " ncmd"}, 32'(n), 32'(v.ncmd));
    chk({p, " done cnt"}, 32'(nd), 32'(v.done));
    chk({p, " err cnt"}, 32'(ne), 32'(v.err));
    chk({p, " ready"}, 32'(desc_ready), 32'd1);
    if (v.ncmd > 0) begin
      chk({p, " latency"}, 32'(first), 32'd1);
      chk({p, " last cyc"}, 32'(lcyc),
          32'(2 * v.ncmd - 1));
      chk({p, " done cyc"}, 32'(dcyc), 32'(lcyc));
    end
  endtask

  initial begin
    int hs, nc, ne;
    rst = 1'b1;
    desc_valid = 1'b0;
    desc_addr = '0;
    desc_id = '0;
    desc_size = '0;
    desc_bytes = '0;
    cmd_ready = 1'b0;
    cmd_abort = 1'b0;

    addv(32'h1000, 3'd2, 32'd64, 2'd1, 1, 1, 0);
    addc(0, 32'h1000, 32'd15);
    addv(32'h0FF0, 3'd2, 32'd64, 2'd2, 2, 1, 0);
    addc(0, 32'h0FF0, 32'd3);
    addc(1, 32'h1000, 32'd11);
    addv(32'h0, 3'd2, 32'd2048, 2'd3, 2, 1, 0);
    addc(0, 32'h0, 32'd255);
    addc(1, 32'h400, 32'd255);
    addv(32'h1002, 3'd2, 32'd16, 2'd0, 0, 0, 1);
    addv(32'h0, 3'd3, 32'd8, 2'd0, 0, 0, 1);
    addv(32'h1004, 3'd2, 32'd10, 2'd0, 0, 0, 1);
    addv(32'h100, 3'd2, 32'd0, 2'd1, 0, 1, 0);
    addv(32'h10, 3'd0, 32'd3, 2'd2, 1, 1, 0);
    addc(0, 32'h10, 32'd2);
    addv(32'hFFFF_FFF8, 3'd1, 32'd16, 2'd3, 2, 1, 0);
    addc(0, 32'hFFFF_FFF8, 32'd3);
    addc(1, 32'h0, 32'd3);
    addv(32'h0FFE, 3'd1, 32'd1030, 2'd1, 4, 1, 0);
    addc(0, 32'h0FFE, 32'd0);
    addc(1, 32'h1000, 32'd255);
    addc(2, 32'h1200, 32'd255);
    addc(3, 32'h1400, 32'd1);

    tick();
    tick();
    chk("rst ready", 32'(desc_ready), 32'd1);
    chk("rst valid", 32'(cmd_valid), 32'd0);
    chk("rst done/err", {30'd0, desc_done, desc_err}, 32'd0);
    chk("rst addr", cmd_addr, 32'd0);
    chk("rst len", cmd_len, 32'd0);
    chk("rst id/size", {27'd0, cmd_id, cmd_size}, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < nv; k++) run_vec(k);

    cmd_abort = 1'b1;
    tick();
    tick();
    chk("idle abort err", 32'(desc_err), 32'd0);
    cmd_abort = 1'b0;
    tick();

    cmd_ready = 1'b0;
    send(32'h2000, 3'd2, 32'd32, 2'd2);
    wait_valid("bp");
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(cmd_valid), 32'd1);
      chk("bp addr", cmd_addr, 32'h2000);
      chk("bp len", cmd_len, 32'd7);
      chk("bp done", 32'(desc_done), 32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    #1;
    chk("bp final done", 32'(desc_done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid) hs++;
      tick();
    end
    chk("bp handshakes", 32'(hs), 32'd1);

    cmd_ready = 1'b0;
    send(32'h0, 3'd2, 32'd3072, 2'd1);
    wait_valid("abort");
    chk("abort len", cmd_len, 32'd255);
    cmd_ready = 1'b1;
    cmd_abort = 1'b1;
    #1;
    chk("abort no done", 32'(desc_done), 32'd0);
    tick();
    cmd_abort = 1'b0;
    chk("abort valid", 32'(cmd_valid), 32'd0);
    chk("abort err", 32'(desc_err), 32'd1);
    chk("abort ready", 32'(desc_ready), 32'd1);
    nc = 0;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid || desc_done) nc++;
      if (desc_err) ne++;
    end
    chk("abort no cmds", 32'(nc), 32'd0);
    chk("abort err once", 32'(ne), 32'd0);

    cmd_ready = 1'b0;
    send(32'h3000, 3'd2, 32'd64, 2'd3);
    wait_valid("rst mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid valid", 32'(cmd_valid), 32'd0);
    chk("rst mid ready", 32'(desc_ready), 32'd1);
    chk("rst mid addr", cmd_addr, 32'd0);
    cmd_ready = 1'b1;
    nc = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid || desc_done || desc_err) nc++;
      tick();
    end
    chk("rst mid quiet", 32'(nc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_burst_splitter.md
Name: dma_burst_splitter

Overview:
- Command-generation stage directly upstream of the DMAC command port.
- Accepts one transfer descriptor (start address, total byte count, beat size, ID) and splits it into legal AXI INCR bursts.
- Bursts never exceed MAX_BEATS and never cross a 4 KB boundary.
- Each burst is issued on the cmd_* handshake that drives the read and write masters.

Parameters:
- AXI_ID_WD, 2, ID width.
- AXI_ADDR_WD, 32, address and byte-count width.
- AXI_STRB_WD, 4, data bus bytes; max legal size = log2(AXI_STRB_WD).
- MAX_BEATS, 256, beat limit per burst (1..256).

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESET  in  1  reset.
- desc_valid  in  1  descriptor valid.
- desc_addr  in  AXI_ADDR_WD  start byte address.
- desc_id  in  AXI_ID_WD  transaction ID.
- desc_size  in  3  AXI beat size code.
- desc_bytes  in  AXI_ADDR_WD  total bytes.
- desc_ready  out  1  descriptor accepted.
- desc_done  out  1  one-cycle pulse, descriptor fully issued.
- desc_err  out  1  one-cycle pulse, descriptor rejected or aborted.
- cmd_valid  out  1  burst command valid.
- cmd_addr  out  AXI_ADDR_WD  burst start address.
- cmd_id  out  AXI_ID_WD  = latched desc_id.
- cmd_burst  out  2  constant 2'b01 (INCR).
- cmd_size  out  3  = latched desc_size.
- cmd_len  out  AXI_ADDR_WD  beats-1; upper bits zero above bit 7.
- cmd_ready  in  1  DMAC accepts command.
- cmd_abort  in  1  DMAC abort.

Behaviour:
- Interface (already decided): one clock AXI_ACLK; AXI_ARESET is synchronous and active-high.
- Reset values: state IDLE; desc_ready=1; cmd_valid=0; desc_done=0; desc_err=0; cmd_addr, cmd_len, cmd_id, cmd_size = 0.
- Reset mid-operation discards the descriptor. No command is emitted after reset.
- States: IDLE, CALC, ISSUE.
- IDLE:
  - desc_ready=1. Accept on desc_valid&desc_ready.
  - Latch addr, id, size, and remaining_beats = desc_bytes>>size.
  - Reject (desc_err pulse next cycle, stay IDLE) if any of:
    - desc_size > log2(AXI_STRB_WD);
    - desc_addr not aligned to 1<<size;
    - desc_bytes not a multiple of 1<<size.
  - desc_bytes==0: desc_done pulse next cycle, no command, stay IDLE.
  - Otherwise go to CALC.
- CALC (1 cycle, registered):
  - beats_4k = (4096 - addr[11:0]) >> size.
  - beats = min(remaining_beats, beats_4k, MAX_BEATS).
  - cmd_len = beats-1; cmd_addr = addr.
  - Go to ISSUE.
- ISSUE:
  - cmd_valid=1. All cmd_* fields stable until cmd_ready.
  - On handshake: addr += beats<<size; remaining -= beats.
  - If remaining==0: go to IDLE and pulse desc_done the same cycle as the final handshake. Else go to CALC.
- Latency:
  - Descriptor accept to first cmd_valid: 2 cycles.
  - Between bursts: 1 idle cycle (CALC).
- desc_ready=0 outside IDLE; one descriptor is in flight at a time.
- cmd_abort, in CALC or ISSUE:
  - Next cycle: cmd_valid=0, desc_err pulse, state IDLE, remaining cleared.
  - Abort takes priority over a simultaneous cmd_ready handshake: no desc_done, no further bursts.
  - cmd_abort in IDLE is ignored.
- Arithmetic:
  - remaining_beats and beat math use AXI_ADDR_WD bits.
  - Address increment wraps modulo 2^AXI_ADDR_WD without error.
  - The 4 KB calculation uses addr[11:0] only.
- desc_done and desc_err never assert in the same cycle.

Decomposition:
- Shared package dma_pkg:
  - BURST_INCR = 2'b01;
  - BOUNDARY_4K = 4096;
  - state enum {IDLE, CALC, ISSUE};
  - function max_size(AXI_STRB_WD).
- Sub-module dma_burst_calc: combinational min(remaining, 4 KB beats, MAX_BEATS) given addr, size, remaining. Registered by the parent in CALC.

Test Plan:
- Aligned single burst: addr=0x1000, size=2, bytes=64 → one cmd, addr 0x1000, len 15, burst 01; desc_done on handshake.
- 4 KB crossing: addr=0x0FF0, size=2, bytes=64 → cmd (0x0FF0, len 3) then cmd (0x1000, len 11); no burst spans 0x1000.
- Beat limit: addr=0, size=2, bytes=2048, MAX_BEATS=256 → cmds (0x000, len 255), (0x400, len 255); done after the second.
- Backpressure: hold cmd_ready=0 for 5 cycles in ISSUE → cmd_* stable throughout; single handshake counted.
- Illegal descriptors → desc_err pulse, no cmd_valid, desc_ready stays 1:
  - addr=0x1002, size=2;
  - size=3 with AXI_STRB_WD=4.
  - Also: bytes=0 → desc_done only.
- Abort and reset:
  - cmd_abort together with cmd_ready during the first of 3 bursts → no more cmds, desc_err pulse, back to IDLE.
  - AXI_ARESET mid-ISSUE → cmd_valid=0 next cycle.
